keypad_digit_rx: RTL and testbench
==================================

Name: keypad_digit_rx

Overview:
Receiving end of the keypad scanner's keypress/alarm interface. It accepts the scanner's one-cycle key strobe with the raw {cols, rows} code and decodes it to a hex digit. It keeps a two-digit history (newest and previous) and time-multiplexes both digits onto a dual common-anode seven-segment display. It sits between the scanner state machine and the display pins in the keypad lab top level.

Parameters:
REFRESH_CYCLES, 24000, int_osc cycles per display slot (one digit lit per slot); must be >= 4.
DEAD_CYCLES, 240, cycles at the start of each slot with both anodes off (anti-ghosting); must be < REFRESH_CYCLES.

Ports:
int_osc  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
keypress  input  8  raw key code {cols[3:0], rows[3:0]}, both active-low one-hot; valid when alarm is sampled high.
alarm  input  1  key strobe from the scanner; nominally one cycle, may be held longer.
digit_new  output  4  most recently accepted digit.
digit_old  output  4  digit accepted before digit_new.
key_valid  output  1  one-cycle pulse when a digit is accepted.
key_error  output  1  one-cycle pulse when a strobe carries a malformed code.
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
an  output  2  anode enables, active-low; an[0] = new digit, an[1] = old digit.

Behaviour:
- Reset (sync, active-high, dominates all other inputs on the same edge):
  - digit_new = digit_old = 0, key_valid = key_error = 0.
  - loaded count = 0, refresh counter = 0, sel = 0.
  - an = 2'b11, seg = 7'b1111111.
  - The alarm edge-detect register is cleared to 0.
  - Reset asserted mid-slot or mid-strobe discards the pending strobe.
- Strobe acceptance:
  - Register alarm_q each cycle; the accept condition is alarm & ~alarm_q (rising edge only).
  - Holding alarm high for N cycles yields exactly one event.
- Decode:
  - Row index r = position of the single 0 in rows; column index c = position of the single 0 in cols.
  - Layout by r: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D (entries listed for c = 0..3).
  - Example: keypress 8'hDD (c1, r1) decodes to 5.
- Latency and event outputs:
  - Edge sampled at edge N; outputs update at edge N+1.
  - Valid code: digit_old <= digit_new, digit_new <= decoded, key_valid = 1 for exactly that cycle, loaded count increments, saturating at 2.
  - Malformed code (either nibble not exactly one zero): key_error = 1 for one cycle; digits and loaded count unchanged.
  - key_valid and key_error are never high together.
- Display multiplexer:
  - The refresh counter runs 0..REFRESH_CYCLES-1 and wraps.
  - On wrap, sel toggles.
  - sel = 0 shows digit_new on an = 2'b10; sel = 1 shows digit_old on an = 2'b01.
  - While counter < DEAD_CYCLES: an = 2'b11, seg = 7'b1111111.
  - Blanking: if the selected digit is not yet loaded (new needs count >= 1, old needs count = 2), an = 2'b11 and seg = 7'b1111111 for the whole slot.
  - seg and an are registered: they reflect the counter/sel/digits of the previous cycle.
  - A digit change mid-slot appears on seg one cycle after digit_new changes.
- Hex font (active-low {g..a}):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- Counter width is $clog2(REFRESH_CYCLES); there is no overflow beyond the wrap.

Test Plan:
- Assert reset 3 cycles, then release with alarm = 0 -> an = 11, seg = 1111111, digit_new = digit_old = 0, no pulses, for 4 full slots (bench: REFRESH_CYCLES = 8, DEAD_CYCLES = 2).
- One-cycle alarm with keypress 8'hEE, then 8'hDD -> key_valid pulses one cycle after each strobe; digit_new = 5, digit_old = 1; sel = 0 slot shows seg 0010010 on an = 10 after 2 dead cycles; sel = 1 slot shows 1111001 on an = 01.
- Single strobe 8'h7E after reset -> digit_new = A; an[0] slot lit with 0001000; an[1] slot stays blank (an = 11) because only one digit is loaded.
- Strobe with keypress 8'hEC -> key_error one cycle, key_valid = 0, digits unchanged; then alarm held high 5 cycles with 8'hBB (decodes to 9) -> exactly one key_valid pulse.
- Reset asserted mid-slot while alarm rises on the same edge -> next cycle digits = 0, loaded = 0, an = 11; the strobe is not accepted.
- Counter boundary: observe cycles 7 -> 0 of the refresh count -> sel toggles exactly at the wrap; anodes are off for cycles 0-1 of each slot, then the correct anode asserts at cycle 2.

Source files
------------

// File: rtl/keypad_digit_rx.sv
// rtl/keypad_digit_rx.sv - keypad strobe decoder with two-digit history and muxed seven-segment drive
// Decodes scanner key strobes to hex digits and time-multiplexes newest/previous digit onto two anodes.
module keypad_digit_rx #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int DEAD_CYCLES    = 240
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [7:0] keypress,
  input  logic       alarm,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid,
  output logic       key_error,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_COUNT = CW'(DEAD_CYCLES);

  // Returns {found, index} for a nibble with exactly one low bit.
  function automatic logic [2:0] find_zero(input logic [3:0] v);
    case (v)
      4'b1110: find_zero = 3'b100;
      4'b1101: find_zero = 3'b101;
      4'b1011: find_zero = 3'b110;
      4'b0111: find_zero = 3'b111;
      default: find_zero = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] key_digit(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_digit = 4'h1;
      4'b00_01: key_digit = 4'h2;
      4'b00_10: key_digit = 4'h3;
      4'b00_11: key_digit = 4'hA;
      4'b01_00: key_digit = 4'h4;
      4'b01_01: key_digit = 4'h5;
      4'b01_10: key_digit = 4'h6;
      4'b01_11: key_digit = 4'hB;
      4'b10_00: key_digit = 4'h7;
      4'b10_01: key_digit = 4'h8;
      4'b10_10: key_digit = 4'h9;
      4'b10_11: key_digit = 4'hC;
      4'b11_00: key_digit = 4'hE;
      4'b11_01: key_digit = 4'h0;
      4'b11_10: key_digit = 4'hF;
      default:  key_digit = 4'hD;
    endcase
  endfunction

  function automatic logic [6:0] hex_font(input logic [3:0] d);
    case (d)
      4'h0: hex_font = 7'b1000000;
      4'h1: hex_font = 7'b1111001;
      4'h2: hex_font = 7'b0100100;
      4'h3: hex_font = 7'b0110000;
      4'h4: hex_font = 7'b0011001;
      4'h5: hex_font = 7'b0010010;
      4'h6: hex_font = 7'b0000010;
      4'h7: hex_font = 7'b1111000;
      4'h8: hex_font = 7'b0000000;
      4'h9: hex_font = 7'b0010000;
      4'hA: hex_font = 7'b0001000;
      4'hB: hex_font = 7'b0000011;
      4'hC: hex_font = 7'b1000110;
      4'hD: hex_font = 7'b0100001;
      4'hE: hex_font = 7'b0000110;
      default: hex_font = 7'b0001110;
    endcase
  endfunction

  logic          alarm_q;
  logic [1:0]    loaded;
  logic [CW-1:0] refresh_cnt;
  logic          sel;

  logic [2:0] row_hit;
  logic [2:0] col_hit;
  logic       strobe;
  logic       code_ok;
  logic [3:0] decoded;
  logic       slot_loaded;
  logic [6:0] next_seg;
  logic [1:0] next_an;

  always_comb begin
    row_hit     = find_zero(keypress[3:0]);
    col_hit     = find_zero(keypress[7:4]);
    strobe      = alarm & ~alarm_q;
    code_ok     = row_hit[2] & col_hit[2];
    decoded     = key_digit(row_hit[1:0], col_hit[1:0]);
    slot_loaded = sel ? (loaded == 2'd2) : (loaded != 2'd0);
    next_an     = 2'b11;
    next_seg    = 7'b1111111;
    // Dead window at slot start keeps the outgoing digit from ghosting onto the other anode.
    if (refresh_cnt >= DEAD_COUNT && slot_loaded) begin
      next_an  = sel ? 2'b01 : 2'b10;
      next_seg = hex_font(sel ? digit_old : digit_new);
    end
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      alarm_q     <= 1'b0;
      loaded      <= 2'd0;
      refresh_cnt <= '0;
      sel         <= 1'b0;
      digit_new   <= 4'h0;
      digit_old   <= 4'h0;
      key_valid   <= 1'b0;
      key_error   <= 1'b0;
      seg         <= 7'b1111111;
      an          <= 2'b11;
    end else begin
      alarm_q   <= alarm;
      key_valid <= 1'b0;
      key_error <= 1'b0;
      if (strobe) begin
        if (code_ok) begin
          digit_old <= digit_new;
          digit_new <= decoded;
          key_valid <= 1'b1;
          if (loaded != 2'd2) loaded <= loaded + 2'd1;
        end else begin
          key_error <= 1'b1;
        end
      end
      if (refresh_cnt == LAST_COUNT) begin
        refresh_cnt <= '0;
        sel         <= ~sel;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      seg <= next_seg;
      an  <= next_an;
    end
  end

endmodule

// File: tb/tb_keypad_digit_rx.sv
// tb/tb_keypad_digit_rx.sv - randomized and directed bench for keypad_digit_rx
// A cycle-level behavioural model predicts every output; directed scenarios add fixed expectations.
module tb_keypad_digit_rx;

  localparam int REFRESH = 8;
  localparam int DEAD    = 2;

  logic       int_osc = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] keypress = 8'hFF;
  logic       alarm   = 1'b0;
  logic [3:0] digit_new, digit_old;
  logic       key_valid, key_error;
  logic [6:0] seg;
  logic [1:0] an;

  keypad_digit_rx #(.REFRESH_CYCLES(REFRESH), .DEAD_CYCLES(DEAD)) dut (
    .int_osc(int_osc), .reset(reset), .keypress(keypress), .alarm(alarm),
    .digit_new(digit_new), .digit_old(digit_old), .key_valid(key_valid),
    .key_error(key_error), .seg(seg), .an(an)
  );

  always #5 int_osc = ~int_osc;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Keypad layout by row, columns 0..3, and the active-low hex font.
  int key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int m_cnt, m_sel, m_dn, m_do, m_loaded;
  bit m_aq;
  bit e_kv, e_ke;
  logic [1:0] e_an;
  logic [6:0] e_seg;

  function automatic void decode_key(input logic [7:0] code, output bit ok, output int d);
    int rz = 0, cz = 0, r = 0, c = 0;
    for (int i = 0; i < 4; i++) begin
      if (!code[i])   begin rz++; r = i; end
      if (!code[i+4]) begin cz++; c = i; end
    end
    ok = (rz == 1) && (cz == 1);
    d  = key_map[r*4 + c];
  endfunction

  always @(posedge int_osc) begin
    bit ok, lit;
    int d;
    if (reset) begin
      m_cnt = 0; m_sel = 0; m_dn = 0; m_do = 0; m_loaded = 0; m_aq = 0;
      e_kv = 0; e_ke = 0; e_an = 2'b11; e_seg = 7'h7F;
    end else begin
      lit   = (m_cnt >= DEAD) && (m_sel == 1 ? m_loaded == 2 : m_loaded >= 1);
      e_an  = !lit ? 2'b11 : (m_sel == 1 ? 2'b01 : 2'b10);
      e_seg = lit ? font[m_sel == 1 ? m_do : m_dn] : 7'h7F;
      e_kv = 0; e_ke = 0;
      if (alarm && !m_aq) begin
        decode_key(keypress, ok, d);
        if (ok) begin
          e_kv = 1; m_do = m_dn; m_dn = d;
          if (m_loaded < 2) m_loaded++;
        end else begin
          e_ke = 1;
        end
      end
      m_aq = alarm;
      m_cnt++;
      if (m_cnt == REFRESH) begin m_cnt = 0; m_sel = 1 - m_sel; end
    end
  end

  always @(negedge int_osc) begin
    if (armed) begin
      check_eq("digit_new", digit_new, m_dn);
      check_eq("digit_old", digit_old, m_do);
      check_eq("key_valid", key_valid, e_kv);
      check_eq("key_error", key_error, e_ke);
      check_eq("seg", seg, e_seg);
      check_eq("an", an, e_an);
      check_eq("valid_error_excl", key_valid & key_error, 0);
    end
  end

  int kv_count, lit0, lit1;
  logic [6:0] seg_an0, seg_an1;

  task automatic run(input int n);
    repeat (n) begin
      @(negedge int_osc);
      if (key_valid) kv_count++;
      if (an == 2'b10) begin seg_an0 = seg; lit0++; end
      if (an == 2'b01) begin seg_an1 = seg; lit1++; end
    end
  endtask

  task automatic clear_obs();
    kv_count = 0; lit0 = 0; lit1 = 0; seg_an0 = 7'h7F; seg_an1 = 7'h7F;
  endtask

  task automatic reset_dut(input int n);
    reset = 1'b1; alarm = 1'b0;
    run(n);
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] code, input int hold);
    keypress = code; alarm = 1'b1;
    run(hold);
    alarm = 1'b0;
  endtask

  initial begin
    run(1);
    armed = 1'b1;
    reset_dut(2);

    // Idle after reset: four slots fully blank, no pulses.
    clear_obs();
    run(4 * REFRESH);
    check_eq("idle_lit", lit0 + lit1, 0);
    check_eq("idle_pulses", kv_count, 0);
    check_eq("idle_digit_new", digit_new, 0);

    // Two keys: 1 then 5.
    reset_dut(3);
    strobe(8'hEE, 1);
    check_eq("kv_after_strobe", key_valid, 1);
    run(2);
    strobe(8'hDD, 1);
    run(2);
    check_eq("two_new", digit_new, 4'h5);
    check_eq("two_old", digit_old, 4'h1);
    clear_obs();
    run(4 * REFRESH);
    check_eq("two_seg_an0", seg_an0, 7'b0010010);
    check_eq("two_seg_an1", seg_an1, 7'b1111001);
    check_eq("two_lit0", lit0, 2 * (REFRESH - DEAD));
    check_eq("two_lit1", lit1, 2 * (REFRESH - DEAD));

    // Single key A: old-digit slot stays blank.
    reset_dut(3);
    strobe(8'h7E, 1);
    run(2);
    clear_obs();
    run(4 * REFRESH);
    check_eq("single_new", digit_new, 4'hA);
    check_eq("single_seg_an0", seg_an0, 7'b0001000);
    check_eq("single_lit1", lit1, 0);
    check_eq("single_lit0", lit0, 2 * (REFRESH - DEAD));

    // Malformed code, then a held strobe producing one event.
    strobe(8'hEC, 1);
    check_eq("err_pulse", key_error, 1);
    check_eq("err_no_valid", key_valid, 0);
    run(1);
    check_eq("err_digit_kept", digit_new, 4'hA);
    clear_obs();
    strobe(8'hBB, 5);
    run(3);
    check_eq("held_one_pulse", kv_count, 1);
    check_eq("held_new", digit_new, 4'h9);
    check_eq("held_old", digit_old, 4'hA);

    // Reset and alarm rise on the same edge: strobe discarded.
    run(3);
    keypress = 8'h77; alarm = 1'b1; reset = 1'b1;
    run(1);
    reset = 1'b0; alarm = 1'b0;
    check_eq("rst_new", digit_new, 0);
    check_eq("rst_old", digit_old, 0);
    check_eq("rst_an", an, 2'b11);
    clear_obs();
    run(20);
    check_eq("rst_no_accept", kv_count, 0);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if (!alarm) begin
        if ($urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 3) != 0)
            keypress = {~(4'b0001 << $urandom_range(0, 3)), ~(4'b0001 << $urandom_range(0, 3))};
          else
            keypress = 8'($urandom);
          alarm = 1'b1;
        end
      end else begin
        alarm = ($urandom_range(0, 2) == 0);
      end
      reset = ($urandom_range(0, 199) == 0);
      run(1);
    end
    reset = 1'b0; alarm = 1'b0;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
